// File: rtl/asip_pkg.sv
// Types and constants shared by the modular multiplier and the hazard/stall logic.
package asip_pkg;

    // Modular multiplier FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } modmul_state_t;

    // Operand width used by the EX-stage multiplier.
    localparam int unsigned MODMUL_N = 32;

    // Cycles from an accepted start to the done pulse for a valid operation.
    localparam int unsigned MODMUL_LATENCY = MODMUL_N + 1;

endpackage

// File: rtl/modmul_unit_step.sv
// One interleaved shift-add (Blakley) iteration: r' = 2r + (bit ? a : 0), reduced below n.
module modmul_step #(
    parameter int unsigned N = 32
) (
    input  logic [N+1:0] r,
    input  logic [N-1:0] opa,
    input  logic         mul_bit,
    input  logic [N-1:0] n,
    output logic [N+1:0] r_next
);

    logic [N+1:0] n_ext;
    logic [N+1:0] sum;
    logic [N+1:0] red1;

    // Shift-add followed by up to two conditional subtractions; 2r + a < 3n always fits in N+2 bits.
    always_comb begin
        n_ext  = {2'b00, n};
        sum    = (r << 1) + (mul_bit ? {2'b00, opa} : '0);
        red1   = (sum >= n_ext) ? (sum - n_ext) : sum;
        r_next = (red1 >= n_ext) ? (red1 - n_ext) : red1;
    end

endmodule

// File: rtl/modmul_unit.sv
// Multi-cycle modular multiplier (opa * opb) mod n, one multiplier bit per cycle, MSB first.
module modmul_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [N-1:0] opa,
    input  logic [N-1:0] opb,
    input  logic [N-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] result
);

    import asip_pkg::*;

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    modmul_state_t state_q, state_d;

    logic [N-1:0]  opa_q, opb_q, n_q;
    logic [N+1:0]  r_q;
    logic [N+1:0]  r_next;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  result_q;
    logic          err_q;
    logic          bad_ops;
    logic          accept;

    // Operand legality check applied to the live inputs at the moment of acceptance.
    always_comb begin
        bad_ops = (n == '0) || (opa >= n) || (opb >= n);
        accept  = (state_q == IDLE) && start && !flush;
    end

    modmul_step #(.N(N)) u_step (
        .r       (r_q),
        .opa     (opa_q),
        .mul_bit (opb_q[cnt_q]),
        .n       (n_q),
        .r_next  (r_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush returns to IDLE from any state and wins over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bad_ops ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, accumulator, bit counter, result and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            n_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opa_q <= opa;
                        opb_q <= opb;
                        n_q   <= n;
                        r_q   <= '0;
                        cnt_q <= CW'(N - 1);
                        err_q <= bad_ops;
                        if (bad_ops) begin
                            result_q <= '0;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_q   <= r_next;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            result_q <= r_next[N-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        busy   = (state_q == CALC) || (state_q == DONE);
        done   = (state_q == DONE);
        err    = err_q;
        result = result_q;
    end

endmodule
